alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 57 +++++
 rtl/alu_pipe.sv | 91 +++++++++
 tb/tb_alu_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and status flag bundle shared by the ALU pipeline and benches
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SRL  = 6'b000010;
  localparam logic [OP_W-1:0] OP_SRA  = 6'b000011;
  localparam logic [OP_W-1:0] OP_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND  = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR   = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR  = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR  = 6'b100111;
  localparam logic [OP_W-1:0] OP_SLT  = 6'b101010;
  localparam logic [OP_W-1:0] OP_SLTU = 6'b101011;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result and status flags for one operation
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic [NB_OP-1:0]   op,
  output logic [NB_DATA-1:0] result,
  output alu_flags_t         flags
);

  localparam int MSB = NB_DATA - 1;
  localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

  logic [NB_DATA:0] sum;
  logic [NB_DATA:0] diff;
  logic             big_shift;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    big_shift = (b >= SHIFT_LIMIT);
    result    = '0;
    flags     = '0;
    case (op)
      NB_OP'(OP_ADD): begin
        result         = sum[NB_DATA-1:0];
        flags.carry    = sum[NB_DATA];
        flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      // diff's top bit is the borrow out of the unsigned subtraction
      NB_OP'(OP_SUB): begin
        result         = diff[NB_DATA-1:0];
        flags.carry    = diff[NB_DATA];
        flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      NB_OP'(OP_AND):  result = a & b;
      NB_OP'(OP_OR):   result = a | b;
      NB_OP'(OP_XOR):  result = a ^ b;
      NB_OP'(OP_NOR):  result = ~(a | b);
      NB_OP'(OP_SRA):  result = big_shift ? {NB_DATA{a[MSB]}} : NB_DATA'($signed(a) >>> b);
      NB_OP'(OP_SRL):  result = big_shift ? '0 : (a >> b);
      NB_OP'(OP_SLL):  result = big_shift ? '0 : (a << b);
      NB_OP'(OP_SLT):  result = {{(NB_DATA-1){1'b0}}, ($signed(a) < $signed(b))};
      NB_OP'(OP_SLTU): result = {{(NB_DATA-1){1'b0}}, (a < b)};
      default:         flags.illegal = 1'b1;
    endcase
    if (!flags.illegal) begin
      flags.zero = (result == '0);
      flags.neg  = result[MSB];
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline (operand stage, result stage)
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_neg,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_illegal
);

  logic               s1_valid;
  logic [NB_DATA-1:0] s1_a;
  logic [NB_DATA-1:0] s1_b;
  logic [NB_OP-1:0]   s1_op;

  logic               s2_valid;
  logic [NB_DATA-1:0] s2_result;
  alu_flags_t         s2_flags;

  logic [NB_DATA-1:0] core_result;
  alu_flags_t         core_flags;
  logic               s2_load;
  logic               s1_load;

  // A stage may load when it is empty or its contents leave in the same cycle
  assign s2_load = !s2_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = !i_reset && s1_load;

  alu_core #(
    .NB_DATA(NB_DATA),
    .NB_OP  (NB_OP)
  ) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .op    (s1_op),
    .result(core_result),
    .flags (core_flags)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_a  <= i_data_a;
          s1_b  <= i_data_b;
          s1_op <= i_op;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= core_result;
          s2_flags  <= core_flags;
        end
      end
    end
  end

  assign o_valid    = s2_valid;
  assign o_result   = s2_result;
  assign o_zero     = s2_flags.zero;
  assign o_neg      = s2_flags.neg;
  assign o_carry    = s2_flags.carry;
  assign o_overflow = s2_flags.overflow;
  assign o_illegal  = s2_flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed self-checking bench for alu_pipe
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] op;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_result;
  logic       o_zero, o_neg, o_carry, o_overflow, o_illegal;

  int n_vec = 0;
  int n_bad = 0;

  logic [5:0] legal_ops [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h03, 6'h02, 6'h00, 6'h2a, 6'h2b};

  always #5 clk = ~clk;

  alu_pipe #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(a), .i_data_b(b), .i_op(op), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_zero(o_zero), .o_neg(o_neg), .o_carry(o_carry),
    .o_overflow(o_overflow), .o_illegal(o_illegal)
  );

  // Expected {result, zero, neg, carry, overflow, illegal} from plain integer arithmetic
  function automatic logic [12:0] ref_op(input int ua, input int ub, input int opc);
    int r, sa, sb, s;
    bit z, n, c, v, ill;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 0; v = 0; ill = 0; r = 0;
    case (opc)
      'h20: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      'h22: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      'h24: r = ua & ub;
      'h25: r = ua | ub;
      'h26: r = ua ^ ub;
      'h27: r = ~(ua | ub);
      'h03: r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> ub);
      'h02: r = (ub >= 8) ? 0 : (ua >> ub);
      'h00: r = (ub >= 8) ? 0 : (ua << ub);
      'h2a: r = (sa < sb) ? 1 : 0;
      'h2b: r = (ua < ub) ? 1 : 0;
      default: ill = 1;
    endcase
    r = r & 255;
    z = !ill && (r == 0);
    n = !ill && r[7];
    return {r[7:0], z, n, c, v, ill};
  endfunction

  function automatic logic [12:0] observed();
    return {o_result, o_zero, o_neg, o_carry, o_overflow, o_illegal};
  endfunction

  task automatic pick_op(output logic [7:0] na, output logic [7:0] nb, output logic [5:0] nop);
    na  = 8'($urandom);
    nb  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
    nop = ($urandom_range(0, 15) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 10)];
  endtask

  task automatic test_reset();
    rst = 1; i_valid = 1; i_ready = 1; a = 8'h12; b = 8'h34; op = 6'h20;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: o_valid=%b o_ready=%b, required 0 0", o_valid, o_ready);
    end
    @(negedge clk);
    rst = 0; i_valid = 0;
    #1;
    n_vec++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || observed() !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b valid=%b out=%h, required 1 0 0000",
               o_ready, o_valid, observed());
    end
  endtask

  task automatic test_directed();
    logic [7:0]  ta [9] = '{8'hFF, 8'h80, 8'h01, 8'h90, 8'h90, 8'h81, 8'hFF, 8'hFF, 8'h55};
    logic [7:0]  tb [9] = '{8'h01, 8'h01, 8'h02, 8'h09, 8'h09, 8'h01, 8'h01, 8'h01, 8'h0F};
    logic [5:0]  top[9] = '{6'h20, 6'h22, 6'h22, 6'h03, 6'h02, 6'h00, 6'h2a, 6'h2b, 6'h3F};
    // {result, zero, neg, carry, overflow, illegal}
    logic [12:0] tex[9] = '{{8'h00, 5'b10100}, {8'h7F, 5'b00010}, {8'hFF, 5'b01100},
                            {8'hFF, 5'b01000}, {8'h00, 5'b10000}, {8'h02, 5'b00000},
                            {8'h01, 5'b00000}, {8'h00, 5'b10000}, {8'h00, 5'b00001}};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      i_valid = 1; i_ready = 1; a = ta[i]; b = tb[i]; op = top[i];
      @(negedge clk);
      i_valid = 0;
      #1;
      n_vec++;
      if (o_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL latency_early[%0d]: o_valid=%b, required 0", i, o_valid);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (o_valid !== 1'b1 || observed() !== tex[i]) begin
        n_bad++;
        $display("FAIL directed[%0d] op=%h: valid=%b out=%h, required 1 %h",
                 i, top[i], o_valid, observed(), tex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_q[$];
    logic [12:0] held;
    logic [7:0]  va [5];
    logic [7:0]  vb [5];
    logic [5:0]  vop[5] = '{6'h20, 6'h22, 6'h26, 6'h03, 6'h2a};
    int idx = 0;
    int got = 0;
    int acc = 0;
    for (int i = 0; i < 5; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom);
    end
    @(negedge clk);
    i_ready = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      i_valid = 1; a = va[idx]; b = vb[idx]; op = vop[idx];
      #1;
      if (o_ready) begin
        exp_q.push_back(ref_op(va[idx], vb[idx], vop[idx]));
        idx++; acc++;
      end
      if (c == 2) held = observed();
    end
    n_vec++;
    if (acc != 2 || o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_accepts: accepted=%0d o_ready=%b, required 2 0", acc, o_ready);
    end
    n_vec++;
    if (o_valid !== 1'b1 || observed() !== held) begin
      n_bad++;
      $display("FAIL stall_hold: valid=%b out=%h, required 1 %h", o_valid, observed(), held);
    end
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(negedge clk);
      i_ready = 1;
      i_valid = (idx < 5);
      if (idx < 5) begin a = va[idx]; b = vb[idx]; op = vop[idx]; end
      #1;
      if (o_valid && i_ready) begin
        n_vec++;
        if (exp_q.size() == 0 || observed() !== exp_q[0]) begin
          n_bad++;
          $display("FAIL b2b_order[%0d]: out=%h, required %h", got, observed(),
                   (exp_q.size() != 0) ? exp_q[0] : 13'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(ref_op(va[idx], vb[idx], vop[idx]));
        idx++;
      end
    end
    n_vec++;
    if (got != 5) begin
      n_bad++;
      $display("FAIL b2b_count: got=%0d results, required 5", got);
    end
    @(negedge clk);
    i_valid = 0;
  endtask

  task automatic test_reset_flush();
    int stale = 0;
    @(negedge clk);
    i_ready = 0; i_valid = 1; a = 8'h11; b = 8'h22; op = 6'h20;
    @(negedge clk);
    a = 8'h33; b = 8'h01; op = 6'h22;
    @(negedge clk);
    i_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    n_vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || observed() !== 13'h0) begin
      n_bad++;
      $display("FAIL flush_reset: valid=%b ready=%b out=%h, required 0 1 0000",
               o_valid, o_ready, observed());
    end
    i_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (o_valid) stale++;
    end
    n_vec++;
    if (stale != 0) begin
      n_bad++;
      $display("FAIL flush_stale: %0d stale results after reset, required 0", stale);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp_q[$];
    logic [12:0] prev_out;
    logic        prev_stall = 0;
    logic [7:0]  na, nb;
    logic [5:0]  nop;
    int sent = 0;
    int cyc = 0;
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      pick_op(na, nb, nop);
      i_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      i_ready = (sent >= 10000) || ($urandom_range(0, 3) != 0);
      a = na; b = nb; op = nop;
      #1;
      if (prev_stall) begin
        n_vec++;
        if (o_valid !== 1'b1 || observed() !== prev_out) begin
          n_bad++;
          $display("FAIL rand_hold cyc=%0d: valid=%b out=%h, required 1 %h",
                   cyc, o_valid, observed(), prev_out);
        end
      end
      if (o_valid && i_ready) begin
        n_vec++;
        if (exp_q.size() == 0 || observed() !== exp_q[0]) begin
          n_bad++;
          $display("FAIL rand_result cyc=%0d: out=%h, required %h", cyc, observed(),
                   (exp_q.size() != 0) ? exp_q[0] : 13'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(ref_op(na, nb, nop));
        sent++;
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = observed();
    end
    n_vec++;
    if (sent != 10000 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_drain: sent=%0d pending=%0d, required 10000 0", sent, exp_q.size());
    end
    @(negedge clk);
    i_valid = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
